intbus_rr_arbiter: RTL and testbench
====================================

Name: intbus_rr_arbiter

Overview:
Round-robin arbiter that shares one internal register bus (the bus feeding the bus hub and its register files) between N bus masters. Examples are the AXI3 bridge and on-chip sequencers. It serialises single-word read and write transactions and returns read data or write completion to the granted master. A read timeout guarantees forward progress when no slave answers an address.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2)
ADDR_W, 16, word-address width
DATA_W, 32, data width
TIMEOUT, 255, max WAIT cycles for a read response; 0 = wait forever
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_valid  in  N_MASTERS  per-master request
m_wr  in  N_MASTERS  1 = write, 0 = read
m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  packed write data
m_ready  out  N_MASTERS  one-cycle request-accepted pulse
m_rvalid  out  N_MASTERS  one-cycle completion pulse
m_rdata  out  DATA_W  shared read data, qualified by m_rvalid
m_err  out  1  timeout flag, qualified by m_rvalid
s_addr  out  ADDR_W  bus address
s_wdata  out  DATA_W  bus write data
s_wr  out  1  bus write strobe
s_rd  out  1  bus read strobe
s_rdata  in  DATA_W  bus read data
s_rvalid  in  1  bus read data valid
grant_id  out  max(1,$clog2(N_MASTERS))  index of current or last granted master
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; last_grant = N_MASTERS-1, so master 0 has first priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any m_valid is set, pick the first set bit searching from last_grant+1 modulo N_MASTERS.
  - Latch addr, wdata, wr and id; update last_grant and grant_id; go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (1 cycle):
  - m_ready[g]=1.
  - s_addr/s_wdata drive the latched values.
  - Assert s_wr=1 if write, else s_rd=1.
  - Next state: RESP for a write (writes are posted); WAIT for a read, with the counter cleared.
- WAIT:
  - Counter increments each cycle.
  - On s_rvalid=1, capture s_rdata, set err=0, go to RESP.
  - Otherwise, if TIMEOUT!=0 and the counter reaches TIMEOUT, set rdata=ERR_DATA, err=1, go to RESP.
  - If s_rvalid arrives on the same cycle as expiry, the data wins and err=0.
- RESP (1 cycle): m_rvalid[g]=1, m_err valid; next state IDLE.
- Strobe and pulse widths: s_wr, s_rd, m_ready and m_rvalid are exactly one cycle wide. All outputs are registered.
- Latency, with the request seen in cycle 0:
  - Write: ISSUE at cycle 1, m_rvalid at cycle 2, arbiter back in IDLE at cycle 3.
  - Read: s_rd at cycle 1, s_rvalid no earlier than cycle 2; m_rvalid the cycle after s_rvalid.
- Hold behaviour: m_rdata and m_err hold their values until the next RESP. s_addr and s_wdata hold their last values; they are only meaningful with a strobe.
- Master rule: a master holds m_valid and its payload until it sees m_ready. Payload changes after the IDLE grant cycle are ignored. Dropping m_valid before m_ready is a protocol violation; the latched transaction still completes.
- A master may re-assert a request in the cycle after its m_rvalid. Ungranted requests stay pending.
- s_rvalid outside WAIT is ignored.
- Reset mid-transaction aborts it: no m_rvalid is issued, the next cycle is IDLE with all outputs 0, and last_grant returns to N_MASTERS-1.
- The timeout counter width is $clog2(TIMEOUT+1) and it saturates.

Test Plan:
- Master 0 writes addr 0x0012, data 0x0B0BADED:
  - Cycle 1: s_wr=1, s_addr=0x0012, s_wdata=0x0B0BADED, m_ready=2'b01.
  - Cycle 2: m_rvalid=2'b01, m_err=0.
  - busy=1 in cycles 1-2.
- Master 1 reads addr 0x0014; slave returns s_rdata=0x12345678 with s_rvalid 3 cycles after s_rd:
  - m_rvalid=2'b10 one cycle later, m_rdata=0x12345678, m_err=0.
  - grant_id=1.
- Both masters hold continuous write requests for 6 transactions:
  - Grant order 0,1,0,1,0,1.
  - One s_wr every 3 cycles, no starvation.
- TIMEOUT=8, read with no s_rvalid:
  - m_rvalid exactly 8 WAIT cycles after ISSUE, m_err=1, m_rdata=0xDEADBEEF.
  - A following write completes normally with m_err=0.
- TIMEOUT=8, s_rvalid on the 8th WAIT cycle with s_rdata=0xA5A5A5A5:
  - m_rdata=0xA5A5A5A5, m_err=0.
- reset=1 for one cycle during WAIT:
  - Next cycle all outputs 0 and busy=0; no m_rvalid.
  - A stray s_rvalid afterwards is ignored.
  - The next simultaneous request from both masters grants master 0.

Source files
------------

// File: rtl/intbus_rr_arbiter.sv
// Round-robin arbiter serialising single-word reads/writes from N masters onto one register bus.
// Grant to strobe 1 cycle; writes complete 1 cycle after issue, reads on s_rvalid or timeout.
module intbus_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int TIMEOUT = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
   localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_valid,
   input  logic [N_MASTERS-1:0]          m_wr,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_ready,
   output logic [N_MASTERS-1:0]          m_rvalid,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          m_err,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic                          s_wr,
   output logic                          s_rd,
   input  logic [DATA_W-1:0]             s_rdata,
   input  logic                          s_rvalid,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_MASTERS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ID_W-1:0]      last_q, last_d;
   logic [ID_W-1:0]      gid_q, gid_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 wr_q, wr_d;
   logic                 err_q, err_d;
   logic                 swr_q, swr_d;
   logic                 srd_q, srd_d;
   logic                 busy_q, busy_d;
   logic [N_MASTERS-1:0] ready_q, ready_d;
   logic [N_MASTERS-1:0] rvalid_q, rvalid_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 found;
   logic [ID_W-1:0]      pick;
   logic                 pick_wr;
   logic [ADDR_W-1:0]    pick_addr;
   logic [DATA_W-1:0]    pick_wdata;

   function automatic logic [N_MASTERS-1:0] onehot(input logic [ID_W-1:0] id);
      onehot = '0;
      onehot[id] = 1'b1;
   endfunction

   // Two passes: masters above the last grant first, then wrap around to the rest.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!found && m_valid[i] && (ID_W'(i) > last_q)) begin
            found = 1'b1;
            pick  = ID_W'(i);
         end
      end
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!found && m_valid[i] && (ID_W'(i) <= last_q)) begin
            found = 1'b1;
            pick  = ID_W'(i);
         end
      end
      pick_wr    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (ID_W'(i) == pick) begin
            pick_wr    = m_wr[i];
            pick_addr  = m_addr[i*ADDR_W +: ADDR_W];
            pick_wdata = m_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gid_d    = gid_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      wr_d     = wr_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      swr_d    = 1'b0;
      srd_d    = 1'b0;
      ready_d  = '0;
      rvalid_d = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               last_d  = pick;
               gid_d   = pick;
               addr_d  = pick_addr;
               wdata_d = pick_wdata;
               wr_d    = pick_wr;
               ready_d = onehot(pick);
               swr_d   = pick_wr;
               srd_d   = !pick_wr;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wr_q) begin
               rvalid_d = onehot(gid_q);
               err_d    = 1'b0;
               state_d  = S_RESP;
            end else begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            // Data arriving on the expiry cycle still wins over the timeout.
            if (s_rvalid) begin
               rdata_d  = s_rdata;
               err_d    = 1'b0;
               rvalid_d = onehot(gid_q);
               state_d  = S_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               rdata_d  = ERR_DATA;
               err_d    = 1'b1;
               rvalid_d = onehot(gid_q);
               state_d  = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         last_q   <= LAST_RST;
         gid_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         swr_q    <= 1'b0;
         srd_q    <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gid_q    <= gid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         swr_q    <= swr_d;
         srd_q    <= srd_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign m_ready  = ready_q;
   assign m_rvalid = rvalid_q;
   assign m_rdata  = rdata_q;
   assign m_err    = err_q;
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;
   assign s_wr     = swr_q;
   assign s_rd     = srd_q;
   assign grant_id = gid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_intbus_rr_arbiter.sv
// Bench for intbus_rr_arbiter: transaction-age reference model checked every cycle, plus directed literals.
module tb_intbus_rr_arbiter;
   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic            clk;
   logic            reset;
   logic [N-1:0]    m_valid, m_wr, m_ready, m_rvalid;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
   logic            m_err, s_wr, s_rd, s_rvalid, busy;
   logic [AW-1:0]   s_addr;
   logic [0:0]      grant_id;

   intbus_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .m_valid(m_valid), .m_wr(m_wr), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .m_err(m_err), .s_addr(s_addr), .s_wdata(s_wdata), .s_wr(s_wr), .s_rd(s_rd),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      else
         passed++;
   endtask

   task automatic fail_now(input string name);
      total++;
      $display("FAIL %s: no DUT response within the cycle budget (cycle %0d)", name, cyc);
   endtask

   // Reference model: a granted transaction has an age (1 = issue cycle) and completes by rule.
   logic [N-1:0]  e_ready = '0, e_rvalid = '0;
   logic          e_swr = 1'b0, e_srd = 1'b0, e_busy = 1'b0, e_err = 1'b0;
   logic [AW-1:0] e_saddr = '0;
   logic [DW-1:0] e_swdata = '0, e_rdata = '0;
   logic [0:0]    e_gid = '0;
   int            last_g = N - 1;
   int            g = 0;
   int            age = 0;
   bit            active = 1'b0;
   bit            cur_wr = 1'b0;

   initial begin : model
      logic [N-1:0] nrdy, nrv;
      logic nwr, nrd;
      bit fnd;
      int idx;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("m_ready", m_ready, e_ready);
         chk("m_rvalid", m_rvalid, e_rvalid);
         chk("s_wr", s_wr, e_swr);
         chk("s_rd", s_rd, e_srd);
         chk("busy", busy, e_busy);
         chk("grant_id", grant_id, e_gid);
         chk("s_addr", s_addr, e_saddr);
         chk("s_wdata", s_wdata, e_swdata);
         chk("m_rdata", m_rdata, e_rdata);
         chk("m_err", m_err, e_err);
         nrdy = '0; nrv = '0; nwr = 1'b0; nrd = 1'b0;
         if (reset) begin
            active = 1'b0; last_g = N - 1; e_gid = '0;
            e_saddr = '0; e_swdata = '0; e_rdata = '0; e_err = 1'b0;
         end else if (!active) begin
            fnd = 1'b0;
            for (int k = 1; k <= N; k++) begin
               idx = (last_g + k) % N;
               if (!fnd && m_valid[idx]) begin fnd = 1'b1; g = idx; end
            end
            if (fnd) begin
               active = 1'b1; age = 1; last_g = g; e_gid = 1'(g);
               cur_wr = m_wr[g];
               e_saddr = m_addr[g*AW +: AW];
               e_swdata = m_wdata[g*DW +: DW];
               nrdy[g] = 1'b1; nwr = cur_wr; nrd = !cur_wr;
            end
         end else if (e_rvalid != '0) begin
            active = 1'b0;
         end else begin
            if (age == 1) begin
               if (cur_wr) begin nrv[g] = 1'b1; e_err = 1'b0; end
            end else if (s_rvalid) begin
               nrv[g] = 1'b1; e_rdata = s_rdata; e_err = 1'b0;
            end else if (TO > 0 && age - 1 == TO) begin
               nrv[g] = 1'b1; e_rdata = ERR; e_err = 1'b1;
            end
            age++;
         end
         e_ready = nrdy; e_rvalid = nrv; e_swr = nwr; e_srd = nrd; e_busy = active;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int m, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int ic);
      ic = -1;
      m_valid[m] = 1'b1; m_wr[m] = wr;
      m_addr[m*AW +: AW] = a; m_wdata[m*DW +: DW] = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_ready[m]) begin ic = cyc; break; end
      end
      if (ic < 0) fail_now("issue grant wait");
      tick();
      m_valid[m] = 1'b0;
   endtask

   task automatic wait_rv(output int rc);
      rc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (m_rvalid != '0) begin rc = cyc; break; end
      end
      if (rc < 0) fail_now("m_rvalid wait");
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      int iss, rc, n;
      int order[6];
      int wcyc[6];
      reset = 1'b1; m_valid = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
      s_rdata = '0; s_rvalid = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset busy", busy, 1'b0);
      chk("reset m_ready", m_ready, 2'b00);
      chk("reset m_rdata", m_rdata, 32'h0);
      tick();

      // Master 0 write
      m_valid = 2'b01; m_wr = 2'b01;
      m_addr[15:0] = 16'h0012; m_wdata[31:0] = 32'h0B0BADED;
      tick();
      @(negedge clk);
      chk("t1 s_wr", s_wr, 1'b1);
      chk("t1 s_addr", s_addr, 16'h0012);
      chk("t1 s_wdata", s_wdata, 32'h0B0BADED);
      chk("t1 m_ready", m_ready, 2'b01);
      chk("t1 busy issue", busy, 1'b1);
      tick();
      m_valid = 2'b00;
      @(negedge clk);
      chk("t1 m_rvalid", m_rvalid, 2'b01);
      chk("t1 m_err", m_err, 1'b0);
      chk("t1 busy resp", busy, 1'b1);
      tick();
      @(negedge clk);
      chk("t1 busy idle", busy, 1'b0);
      tick();

      // Master 1 read, slave answers 3 cycles after s_rd
      issue(1, 1'b0, 16'h0014, 32'h0, iss);
      repeat (2) tick();
      s_rvalid = 1'b1; s_rdata = 32'h12345678;
      tick();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("t2 latency", cyc - iss, 4);
      chk("t2 m_rvalid", m_rvalid, 2'b10);
      chk("t2 m_rdata", m_rdata, 32'h12345678);
      chk("t2 m_err", m_err, 1'b0);
      chk("t2 grant_id", grant_id, 1'b1);
      tick();

      // Both masters stream writes
      m_valid = 2'b11; m_wr = 2'b11;
      m_addr = {16'h0041, 16'h0040}; m_wdata = {32'h1111_0001, 32'h0000_0000};
      n = 0;
      for (int k = 0; k < 40 && n < 6; k++) begin
         @(negedge clk);
         if (m_ready != '0) begin
            order[n] = m_ready[1] ? 1 : 0;
            wcyc[n] = cyc;
            chk("t3 s_wr with grant", s_wr, 1'b1);
            n++;
         end
      end
      if (n < 6) fail_now("t3 six grants");
      tick();
      m_valid = 2'b00;
      for (int i = 0; i < n; i++) begin
         chk("t3 grant order", order[i], i % 2);
         if (i > 0) chk("t3 write spacing", wcyc[i] - wcyc[i-1], 3);
      end
      repeat (3) tick();

      // Read with no slave answer times out
      issue(0, 1'b0, 16'h0020, 32'h0, iss);
      wait_rv(rc);
      chk("t4 timeout latency", rc - iss, 9);
      chk("t4 m_rvalid", m_rvalid, 2'b01);
      chk("t4 m_err", m_err, 1'b1);
      chk("t4 m_rdata", m_rdata, 32'hDEADBEEF);
      tick();
      issue(1, 1'b1, 16'h0022, 32'h0000_0055, iss);
      wait_rv(rc);
      chk("t4 write after timeout err", m_err, 1'b0);
      chk("t4 write after timeout rvalid", m_rvalid, 2'b10);
      tick();

      // s_rvalid on the final wait cycle beats the timeout
      issue(1, 1'b0, 16'h0024, 32'h0, iss);
      repeat (7) tick();
      s_rvalid = 1'b1; s_rdata = 32'hA5A5A5A5;
      tick();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("t5 latency", cyc - iss, 9);
      chk("t5 m_rvalid", m_rvalid, 2'b10);
      chk("t5 m_rdata", m_rdata, 32'hA5A5A5A5);
      chk("t5 m_err", m_err, 1'b0);
      tick();

      // Reset during a pending read
      issue(0, 1'b0, 16'h0030, 32'h0, iss);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t6 busy", busy, 1'b0);
      chk("t6 m_rvalid", m_rvalid, 2'b00);
      chk("t6 s_rd", s_rd, 1'b0);
      chk("t6 s_addr", s_addr, 16'h0);
      chk("t6 m_rdata", m_rdata, 32'h0);
      tick();
      s_rvalid = 1'b1; s_rdata = 32'h0000_0077;
      tick();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("t6 stray m_rvalid", m_rvalid, 2'b00);
      chk("t6 stray m_rdata", m_rdata, 32'h0);
      tick();
      m_valid = 2'b11; m_wr = 2'b11;
      m_addr = {16'h0051, 16'h0050}; m_wdata = {32'h5151_5151, 32'h5050_5050};
      rc = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (m_ready != '0) begin rc = cyc; break; end
      end
      if (rc < 0) fail_now("t6 first grant");
      else chk("t6 first grant after reset", m_ready, 2'b01);
      tick();
      m_valid[0] = 1'b0;
      rc = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (m_ready[1]) begin rc = cyc; break; end
      end
      if (rc < 0) fail_now("t6 pending master 1 grant");
      tick();
      m_valid = 2'b00;
      repeat (5) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
